// File: rtl/regfile_core.sv
// regfile_core: 32 x DATA_WIDTH register file, one write port, two read ports, r0 reads as zero.
// Latency: a write commits on the rising edge; it is visible on the read ports after that edge.
//   Reads are combinational.
// Backpressure: none. A write is accepted every cycle. Multi-hot selects are dropped and flagged.
//
// Optional build macro REGFILE_BYPASS_EN: forwards same-cycle write data to a matching read port.
//
// Ports:
//   clock, ctrl_reset        - rising-edge clock, synchronous active-high reset
//   write_sel                - one-hot write select from the address decoder (all-zero = idle)
//   data_writeReg            - write data
//   ctrl_readRegA/B          - read addresses
//   data_readRegA/B          - read data
//   sel_err                  - sticky: a multi-hot write_sel has been seen since reset
//   write_count              - committed writes since reset (wraps at 16 bits)
module regfile_core #(
  parameter int unsigned             DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic [31:0]           write_sel,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [4:0]            ctrl_readRegA,
  input  logic [4:0]            ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  sel_err,
  output logic [15:0]           write_count
);

  // Entry 0 is never stored; the read mux returns zero for address 0.
  logic [DATA_WIDTH-1:0] regs [1:31];

  logic       sel_any;
  logic       sel_onehot;
  logic       sel_multi;
  logic [4:0] wr_idx;
  logic       wr_en;

  // x & (x-1) clears the lowest set bit; a zero result means at most one bit was set.
  assign sel_any    = |write_sel;
  assign sel_onehot = sel_any && ((write_sel & (write_sel - 32'd1)) == 32'd0);
  assign sel_multi  = sel_any && !sel_onehot;

  // Encode the one-hot select. Only meaningful when sel_onehot is high.
  always_comb begin
    wr_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (write_sel[i]) wr_idx = i[4:0];
    end
  end

  // Bit-0 selects are legal but commit nothing.
  assign wr_en = !ctrl_reset && sel_onehot && (wr_idx != 5'd0);

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= RESET_VALUE;
      sel_err     <= 1'b0;
      write_count <= 16'd0;
    end else begin
      if (wr_en) begin
        regs[wr_idx] <= data_writeReg;
        write_count  <= write_count + 16'd1;
      end
      if (sel_multi) sel_err <= 1'b1;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd(input logic [4:0] addr);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (addr != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (addr == wr_idx)) v = data_writeReg;
      else                           v = regs[addr];
`else
      v = regs[addr];
`endif
    end
    return v;
  endfunction

  assign data_readRegA = rd(ctrl_readRegA);
  assign data_readRegB = rd(ctrl_readRegB);

endmodule

// File: tb/tb_regfile_core.sv
// tb_regfile_core: directed vectors with hand-computed expectations for regfile_core.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after the edge.
// Builds with or without REGFILE_BYPASS_EN; only the read-during-write expectation differs.
module tb_regfile_core;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic [31:0] write_sel;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        sel_err;
  logic [15:0] write_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  regfile_core #(.DATA_WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .write_sel     (write_sel),
    .data_writeReg (data_writeReg),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB),
    .sel_err       (sel_err),
    .write_count   (write_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present a write for one edge, then return to idle.
  task automatic do_write(input logic [31:0] sel, input logic [31:0] dat);
    write_sel     = sel;
    data_writeReg = dat;
    tick();
    write_sel     = 32'h0;
  endtask

  initial begin
    ctrl_reset    = 1'b1;
    write_sel     = 32'h0;
    data_writeReg = 32'h0;
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;

    // Reset held for two edges.
    tick();
    tick();
    ctrl_reset = 1'b0;
    settle();
    check("rst_sel_err", {31'd0, sel_err}, 32'd0);
    check("rst_count", {16'd0, write_count}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      ctrl_readRegA = a[4:0];
      ctrl_readRegB = 5'(31 - a);
      settle();
      check("rst_readA", data_readRegA, 32'h0);
      check("rst_readB", data_readRegB, 32'h0);
    end

    // Basic write/read on reg 5.
    do_write(32'h0000_0020, 32'hDEAD_BEEF);
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd5;
    settle();
    check("wr5_readA", data_readRegA, 32'hDEAD_BEEF);
    check("wr5_readB", data_readRegB, 32'hDEAD_BEEF);
    check("wr5_count", {16'd0, write_count}, 32'd1);

    // Second register, distinct data on the two ports.
    do_write(32'h8000_0000, 32'hA5A5_0F0F);
    ctrl_readRegA = 5'd31;
    ctrl_readRegB = 5'd5;
    settle();
    check("wr31_readA", data_readRegA, 32'hA5A5_0F0F);
    check("wr31_readB", data_readRegB, 32'hDEAD_BEEF);
    check("wr31_count", {16'd0, write_count}, 32'd2);

    // Register 0 protection.
    do_write(32'h0000_0001, 32'hFFFF_FFFF);
    ctrl_readRegA = 5'd0;
    settle();
    check("r0_read", data_readRegA, 32'h0);
    check("r0_count", {16'd0, write_count}, 32'd2);
    check("r0_sel_err", {31'd0, sel_err}, 32'd0);

    // Multi-hot select on bits 5 and 6; read reg 5 during the cycle (no forwarding in any build).
    write_sel     = 32'h0000_0060;
    data_writeReg = 32'h1234_5678;
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd6;
    settle();
    check("mh_during_A", data_readRegA, 32'hDEAD_BEEF);
    check("mh_during_B", data_readRegB, 32'h0);
    #1;
    tick();
    write_sel = 32'h0;
    settle();
    check("mh_reg5", data_readRegA, 32'hDEAD_BEEF);
    check("mh_reg6", data_readRegB, 32'h0);
    check("mh_sel_err", {31'd0, sel_err}, 32'd1);
    check("mh_count", {16'd0, write_count}, 32'd2);
    // sel_err is sticky across a later clean write.
    do_write(32'h0000_0100, 32'h0000_0042);
    ctrl_readRegA = 5'd8;
    settle();
    check("sticky_sel_err", {31'd0, sel_err}, 32'd1);
    check("sticky_reg8", data_readRegA, 32'h0000_0042);
    check("sticky_count", {16'd0, write_count}, 32'd3);

    // Reset with a multi-hot select and then with a one-hot write in the same cycle.
    ctrl_reset    = 1'b1;
    write_sel     = 32'h0000_0060;
    data_writeReg = 32'h1111_1111;
    tick();
    write_sel     = 32'h0000_0020;
    data_writeReg = 32'h2222_2222;
    ctrl_readRegA = 5'd5;
    settle();
    check("rst_mh_sel_err", {31'd0, sel_err}, 32'd0);
    check("rst_mh_count", {16'd0, write_count}, 32'd0);
    // No forwarding while reset is high: reg 5 shows its reset value.
    check("rst_nofwd", data_readRegA, 32'h0);
    #1;
    tick();
    ctrl_reset = 1'b0;
    write_sel  = 32'h0;
    settle();
    check("rst_discard_reg5", data_readRegA, 32'h0);
    check("rst_discard_count", {16'd0, write_count}, 32'd0);
    check("rst_discard_err", {31'd0, sel_err}, 32'd0);

    // Read-during-write on reg 9: old 0x11, new 0x22.
    do_write(32'h0000_0200, 32'h0000_0011);
    write_sel     = 32'h0000_0200;
    data_writeReg = 32'h0000_0022;
    ctrl_readRegA = 5'd9;
    ctrl_readRegB = 5'd0;
    settle();
`ifdef REGFILE_BYPASS_EN
    check("rdw_same_cycle", data_readRegA, 32'h0000_0022);
`else
    check("rdw_same_cycle", data_readRegA, 32'h0000_0011);
`endif
    check("rdw_portB_r0", data_readRegB, 32'h0);
    #1;
    tick();
    write_sel = 32'h0;
    settle();
    check("rdw_after_edge", data_readRegA, 32'h0000_0022);
    check("rdw_count", {16'd0, write_count}, 32'd2);

    // Counter wrap: reset, then 65536 writes to reg 3 with data = loop index.
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset    = 1'b0;
    write_sel     = 32'h0000_0008;
    ctrl_readRegA = 5'd3;
    for (int i = 0; i < 65536; i++) begin
      data_writeReg = i;
      tick();
      if (i == 0) begin
        settle();
        check("wrap_first_count", {16'd0, write_count}, 32'd1);
      end
      if (i == 65534) begin
        settle();
        check("wrap_ffff", {16'd0, write_count}, 32'h0000_FFFF);
        check("wrap_reg3_mid", data_readRegA, 32'd65534);
      end
    end
    write_sel = 32'h0;
    settle();
    check("wrap_count", {16'd0, write_count}, 32'h0);
    check("wrap_reg3", data_readRegA, 32'h0000_FFFF);
    check("wrap_sel_err", {31'd0, sel_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
